// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D request arbiter and its wait-state watchdog.
package a2d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_MC = 1'b0,
    OWN_HK = 1'b1
  } arb_owner_e;

  localparam logic [1:0]  STARVE_LIMIT = 2'd3;
  localparam logic [11:0] TIMEOUT_CYC  = 12'd4095;

endpackage

// File: rtl/a2d_arb_wdog.sv
// Wait-state watchdog: counts enabled cycles and flags the last one before TIMEOUT_CYC is reached.
module a2d_arb_wdog
  import a2d_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [11:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TIMEOUT_CYC)) begin
      cnt_d = cnt_q + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted during the TIMEOUT_CYC-th enabled cycle, so the abort lands exactly at the limit.
  assign expired_o = en_i && !clr_i && (cnt_q == (TIMEOUT_CYC - 12'd1));

endmodule

// File: rtl/a2d_arbiter.sv
// Shares one A2D converter between the motion-control (mc) and housekeeping (hk) requesters.
// Define A2D_ARB_TIMEOUT_EN to abort conversions stuck in WAIT after TIMEOUT_CYC cycles and set err.
module a2d_arbiter
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mc_req,
  input  logic [2:0]  mc_chnnl,
  output logic        mc_done,
  input  logic        hk_req,
  input  logic [2:0]  hk_chnnl,
  output logic        hk_done,
  output logic [11:0] res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] a2d_res,
  output logic        err
);

  arb_state_e  state_q, state_d;
  arb_owner_e  owner_q, owner_d;
  logic [2:0]  chnnl_q, chnnl_d;
  logic [11:0] res_q, res_d;
  logic [1:0]  starve_q, starve_d;
  logic        hk_wins;
  logic        tmo_expired;

  // hk yields to mc until it has been passed over STARVE_LIMIT times in a row.
  assign hk_wins = hk_req && (!mc_req || (starve_q == STARVE_LIMIT));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    chnnl_d  = chnnl_q;
    res_d    = res_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (!hk_req) begin
          starve_d = '0;
        end
        if (mc_req || hk_req) begin
          state_d = START;
          if (hk_wins) begin
            owner_d  = OWN_HK;
            chnnl_d  = hk_chnnl;
            starve_d = '0;
          end else begin
            owner_d = OWN_MC;
            chnnl_d = mc_chnnl;
            if (hk_req && (starve_q != STARVE_LIMIT)) begin
              starve_d = starve_q + 2'd1;
            end
          end
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A completion arriving in the same cycle as the timeout still counts as a capture.
        if (cnv_cmplt) begin
          res_d   = a2d_res;
          state_d = DONE;
        end else if (tmo_expired) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_MC;
      chnnl_q  <= '0;
      res_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      chnnl_q  <= chnnl_d;
      res_q    <= res_d;
      starve_q <= starve_d;
    end
  end

  assign strt_cnv = (state_q == START);
  assign mc_done  = (state_q == DONE) && (owner_q == OWN_MC);
  assign hk_done  = (state_q == DONE) && (owner_q == OWN_HK);
  assign chnnl    = chnnl_q;
  assign res      = res_q;

`ifdef A2D_ARB_TIMEOUT_EN
  logic err_q, err_d;

  a2d_arb_wdog u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q != WAIT),
    .en_i      (state_q == WAIT),
    .expired_o (tmo_expired)
  );

  always_comb begin
    err_d = err_q;
    if (state_q == WAIT) begin
      if (cnv_cmplt) begin
        err_d = 1'b0;
      end else if (tmo_expired) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_expired = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_a2d_arbiter.sv
// Bench for a2d_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_a2d_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mc_req, hk_req, cnv_cmplt;
  logic [2:0]  mc_chnnl, hk_chnnl;
  logic [11:0] a2d_res;
  logic        mc_done, hk_done, strt_cnv, err;
  logic [2:0]  chnnl;
  logic [11:0] res;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  a2d_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mc_req    (mc_req),
    .mc_chnnl  (mc_chnnl),
    .mc_done   (mc_done),
    .hk_req    (hk_req),
    .hk_chnnl  (hk_chnnl),
    .hk_done   (hk_done),
    .res       (res),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .a2d_res   (a2d_res),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Acts as the A2D interface for one transaction: completes n cycles after strt_cnv,
  // optionally drops both requests `drop` cycles after strt_cnv, returns what was observed.
  task automatic serve(input int n, input logic [11:0] val, input int drop, input int limit,
                       output int strt_c, output int done_c, output logic [2:0] ch,
                       output int nstrt, output int unstable, output logic dm, output logic dh);
    strt_c = -1; done_c = -1; ch = '0; nstrt = 0; unstable = 0; dm = 1'b0; dh = 1'b0;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (strt_cnv) begin
        nstrt++;
        if (strt_c < 0) begin
          strt_c = cyc;
          ch = chnnl;
        end
      end else if (strt_c >= 0 && chnnl !== ch) begin
        unstable++;
      end
      if (mc_done || hk_done) begin
        done_c = cyc; dm = mc_done; dh = hk_done;
        cnv_cmplt = 1'b0;
        break;
      end
      if (strt_c >= 0 && cyc == strt_c + drop) begin
        mc_req = 1'b0;
        hk_req = 1'b0;
      end
      cnv_cmplt = (strt_c >= 0 && cyc == strt_c + n);
      a2d_res = cnv_cmplt ? val : 12'($urandom);
    end
  endtask

  task automatic test_reset();
    mc_req = 1'b1; hk_req = 1'b1; mc_chnnl = 3'd5; hk_chnnl = 3'd6; cnv_cmplt = 1'b1;
    a2d_res = 12'hFFF;
    tick(); tick(); tick();
    n_vec++; if ({strt_cnv, chnnl, res} !== 16'h0) begin n_err++;
      $display("FAIL reset_data: strt/chnnl/res=%h expected 0", {strt_cnv, chnnl, res}); end
    n_vec++; if ({mc_done, hk_done, err} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags: mc_done/hk_done/err=%b expected 000", {mc_done, hk_done, err}); end
    mc_req = 1'b0; hk_req = 1'b0; cnv_cmplt = 1'b0;
    rst_n = 1'b1;
    tick();
    n_vec++; if ({strt_cnv, chnnl, res, mc_done, hk_done, err} !== 19'h0) begin n_err++;
      $display("FAIL reset_release_idle: outputs=%h expected 0", {strt_cnv, chnnl, res, mc_done, hk_done, err}); end
  endtask

  task automatic test_single();
    int s, d, ns, un; logic [2:0] ch; logic dm, dh;
    mc_chnnl = 3'b100; mc_req = 1'b1; hk_req = 1'b0;
    serve(20, 12'hA5C, -1, 100, s, d, ch, ns, un, dm, dh);
    mc_req = 1'b0;
    n_vec++; if (ch !== 3'd4) begin n_err++; $display("FAIL single_chnnl: got %0d expected 4", ch); end
    n_vec++; if (ns != 1) begin n_err++; $display("FAIL single_strt_pulses: got %0d expected 1", ns); end
    n_vec++; if (d - s + 2 != 23) begin n_err++; $display("FAIL single_latency: got %0d expected 23", d - s + 2); end
    n_vec++; if ({dm, dh} !== 2'b10) begin n_err++; $display("FAIL single_done_owner: mc/hk=%b expected 10", {dm, dh}); end
    n_vec++; if (res !== 12'hA5C) begin n_err++; $display("FAIL single_res: got %h expected a5c", res); end
    n_vec++; if (un != 0) begin n_err++; $display("FAIL single_chnnl_stable: %0d changes expected 0", un); end
    tick();
    n_vec++; if ({mc_done, hk_done, strt_cnv} !== 3'b000) begin n_err++;
      $display("FAIL single_pulse_width: mc/hk/strt=%b expected 000", {mc_done, hk_done, strt_cnv}); end
  endtask

  task automatic test_simultaneous();
    int s1, d1, s2, d2, ns, un; logic [2:0] c1, c2; logic m1, h1, m2, h2;
    mc_chnnl = 3'd1; hk_chnnl = 3'd7; mc_req = 1'b1; hk_req = 1'b1;
    serve(3, 12'h111, -1, 50, s1, d1, c1, ns, un, m1, h1);
    mc_req = 1'b0;
    serve(5, 12'h777, -1, 50, s2, d2, c2, ns, un, m2, h2);
    hk_req = 1'b0;
    n_vec++; if (c1 !== 3'd1 || {m1, h1} !== 2'b10) begin n_err++;
      $display("FAIL simul_first: chnnl=%0d mc/hk=%b expected 1 10", c1, {m1, h1}); end
    n_vec++; if (c2 !== 3'd7 || {m2, h2} !== 2'b01) begin n_err++;
      $display("FAIL simul_second: chnnl=%0d mc/hk=%b expected 7 01", c2, {m2, h2}); end
    n_vec++; if (s2 != d1 + 2) begin n_err++; $display("FAIL simul_gap: strt at %0d expected %0d", s2, d1 + 2); end
    n_vec++; if (res !== 12'h777) begin n_err++; $display("FAIL simul_res: got %h expected 777", res); end
  endtask

  task automatic test_starve();
    int s, d, pd, ns, un; logic [2:0] ch; logic dm, dh;
    mc_chnnl = 3'd2; hk_chnnl = 3'd5; mc_req = 1'b1; hk_req = 1'b1; pd = -1;
    for (int i = 0; i < 4; i++) begin
      serve(2 + i, 12'(i + 1), -1, 50, s, d, ch, ns, un, dm, dh);
      n_vec++;
      if (i < 3 && (ch !== 3'd2 || {dm, dh} !== 2'b10)) begin n_err++;
        $display("FAIL starve_mc_%0d: chnnl=%0d mc/hk=%b expected 2 10", i, ch, {dm, dh}); end
      else if (i == 3 && (ch !== 3'd5 || {dm, dh} !== 2'b01)) begin n_err++;
        $display("FAIL starve_hk_grant: chnnl=%0d mc/hk=%b expected 5 01", ch, {dm, dh}); end
      if (i > 0) begin
        n_vec++; if (s != pd + 2) begin n_err++;
          $display("FAIL starve_b2b_%0d: strt at %0d expected %0d", i, s, pd + 2); end
      end
      pd = d;
    end
    mc_req = 1'b0; hk_req = 1'b0;
    tick();
  endtask

  task automatic test_withdraw();
    int s, d, ns, un; logic [2:0] ch; logic dm, dh;
    hk_chnnl = 3'd6; hk_req = 1'b1;
    serve(8, 12'h3C3, 2, 50, s, d, ch, ns, un, dm, dh);
    n_vec++; if ({dm, dh} !== 2'b01 || ch !== 3'd6) begin n_err++;
      $display("FAIL withdraw_done: chnnl=%0d mc/hk=%b expected 6 01", ch, {dm, dh}); end
    n_vec++; if (d - s + 2 != 11) begin n_err++; $display("FAIL withdraw_latency: got %0d expected 11", d - s + 2); end
    n_vec++; if (res !== 12'h3C3) begin n_err++; $display("FAIL withdraw_res: got %h expected 3c3", res); end
  endtask

`ifdef A2D_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int s, d, ns, un; logic [2:0] ch; logic dm, dh;
    mc_chnnl = 3'd2; mc_req = 1'b1;
    serve(1 << 20, 12'h000, -1, 4300, s, d, ch, ns, un, dm, dh);
    mc_req = 1'b0;
    n_vec++; if (d - s != 4096) begin n_err++; $display("FAIL timeout_cycles: done %0d after strt expected 4096", d - s); end
    n_vec++; if ({dm, dh} !== 2'b10) begin n_err++; $display("FAIL timeout_done_owner: mc/hk=%b expected 10", {dm, dh}); end
    n_vec++; if (res !== 12'h3C3) begin n_err++; $display("FAIL timeout_res_kept: got %h expected 3c3", res); end
    tick(); tick();
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL timeout_err_sticky: got %b expected 1", err); end
    mc_req = 1'b1;
    serve(4, 12'h456, -1, 50, s, d, ch, ns, un, dm, dh);
    mc_req = 1'b0;
    n_vec++; if (err !== 1'b0 || res !== 12'h456) begin n_err++;
      $display("FAIL timeout_err_clear: err=%b res=%h expected 0 456", err, res); end
  endtask
`else
  task automatic test_timeout();
    int s, d, ns, un; logic [2:0] ch; logic dm, dh;
    mc_chnnl = 3'd2; mc_req = 1'b1;
    serve(4200, 12'h5A5, -1, 4400, s, d, ch, ns, un, dm, dh);
    mc_req = 1'b0;
    n_vec++; if (d - s != 4201) begin n_err++; $display("FAIL long_wait_cycles: done %0d after strt expected 4201", d - s); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL long_wait_err: got %b expected 0", err); end
    n_vec++; if ({dm, dh} !== 2'b10 || res !== 12'h5A5) begin n_err++;
      $display("FAIL long_wait_done: mc/hk=%b res=%h expected 10 5a5", {dm, dh}, res); end
  endtask
`endif

  task automatic test_reset_mid_wait();
    int found, bad;
    mc_chnnl = 3'd3; mc_req = 1'b1; found = 0; bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (strt_cnv) begin found = 1; break; end
    end
    n_vec++; if (found != 1) begin n_err++; $display("FAIL rstwait_strt: found=%0d expected 1", found); end
    tick(); tick(); tick();
    #3 rst_n = 1'b0; mc_req = 1'b0;
    #1;
    n_vec++; if ({strt_cnv, chnnl, res, mc_done, hk_done, err} !== 19'h0) begin n_err++;
      $display("FAIL rstwait_async: outputs=%h expected 0", {strt_cnv, chnnl, res, mc_done, hk_done, err}); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    cnv_cmplt = 1'b1; a2d_res = 12'hFFF;
    tick();
    cnv_cmplt = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mc_done || hk_done || strt_cnv || res != 12'h0 || chnnl != 3'd0) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL rstwait_ignore_cmplt: %0d bad cycles expected 0", bad); end
  endtask

  // Randomized clients and A2D responder; the model predicts each grant from the priority and
  // starvation rules, then derives strt/done timing and captured results from the timing rules.
  task automatic test_random();
    int mj, hj, busy_until, exp_strt, exp_done, cmp_at, starve;
    bit own_hk;
    logic exp_m, exp_h;
    logic [2:0] exp_ch;
    logic [11:0] exp_res, cap_val;
    rst_n = 1'b0; mc_req = 1'b0; hk_req = 1'b0; cnv_cmplt = 1'b0;
    tick();
    rst_n = 1'b1;
    mj = 0; hj = 0; busy_until = cyc; exp_strt = -1; exp_done = -1; cmp_at = -1; starve = 0;
    own_hk = 1'b0; exp_ch = '0; exp_res = '0; cap_val = '0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (cyc == exp_done) exp_res = cap_val;
      exp_m = (cyc == exp_done) && !own_hk;
      exp_h = (cyc == exp_done) && own_hk;
      n_vec++; if (strt_cnv !== (cyc == exp_strt)) begin n_err++;
        $display("FAIL rnd_strt @%0d: got %b expected %b", cyc, strt_cnv, cyc == exp_strt); end
      n_vec++; if (mc_done !== exp_m) begin n_err++; $display("FAIL rnd_mc_done @%0d: got %b expected %b", cyc, mc_done, exp_m); end
      n_vec++; if (hk_done !== exp_h) begin n_err++; $display("FAIL rnd_hk_done @%0d: got %b expected %b", cyc, hk_done, exp_h); end
      n_vec++; if (res !== exp_res) begin n_err++; $display("FAIL rnd_res @%0d: got %h expected %h", cyc, res, exp_res); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rnd_err @%0d: got %b expected 0", cyc, err); end
      if (exp_strt >= 0) begin
        n_vec++; if (chnnl !== exp_ch) begin n_err++; $display("FAIL rnd_chnnl @%0d: got %0d expected %0d", cyc, chnnl, exp_ch); end
      end
      if (cyc == exp_strt) begin
        cmp_at = cyc + int'($urandom_range(1, 6));
        exp_done = cmp_at + 1;
        busy_until = exp_done;
      end
      if (mc_done && mj > 0) mj--;
      if (hk_done && hj > 0) hj--;
      if (k < 2850) begin
        if ($urandom_range(0, 15) == 0 && mj < 3) mj++;
        if ($urandom_range(0, 11) == 0 && hj < 3) hj++;
      end
      if (mj > 0 && (!mc_req || mc_done)) mc_chnnl = 3'($urandom);
      if (hj > 0 && (!hk_req || hk_done)) hk_chnnl = 3'($urandom);
      mc_req = (mj > 0);
      hk_req = (hj > 0);
      if (cyc > busy_until) begin
        if (!hk_req) starve = 0;
        if (mc_req || hk_req) begin
          own_hk = hk_req && (!mc_req || starve == 3);
          exp_ch = own_hk ? hk_chnnl : mc_chnnl;
          if (own_hk) starve = 0;
          else if (hk_req && starve < 3) starve++;
          exp_strt = cyc + 1;
          busy_until = 1 << 30;
        end
      end
      cnv_cmplt = (cyc == cmp_at) || (!(cyc > exp_strt && cyc < exp_done) && $urandom_range(0, 3) == 0);
      a2d_res = 12'($urandom);
      if (cyc == cmp_at) cap_val = a2d_res;
    end
    cnv_cmplt = 1'b0; mc_req = 1'b0; hk_req = 1'b0;
    n_vec++; if (mj != 0 || hj != 0) begin n_err++;
      $display("FAIL rnd_drain: pending mc=%0d hk=%0d expected 0 0", mj, hj); end
  endtask

  initial begin
    rst_n = 1'b0; mc_req = 1'b0; hk_req = 1'b0; cnv_cmplt = 1'b0;
    mc_chnnl = '0; hk_chnnl = '0; a2d_res = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_starve();
    test_withdraw();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
